isolde_imm_collector: RTL and testbench
=======================================

Name: isolde_imm_collector

Overview:
- Upstream feeder of the ISOLDE fetch-to-exec handshake. Sits between the fetch word stream and the exec block.
- Detects custom-opcode instruction headers and gathers the 1..4 trailing 32-bit immediate words.
- Presents header and immediates as one stable request (exec_req/gnt/dne protocol) and holds them until the exec block signals done.
- Non-custom words pass straight through to the standard decode path.

Parameters:
- IMM32_OPS, 4, number of immediate slots (1..4).
- CUSTOM_OPCODE, 7'h0B, value of instr[6:0] that marks an ISOLDE header.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- instr_valid_i  in  1  fetch word valid.
- instr_i  in  32  fetch word.
- instr_ready_o  out  1  word accepted when instr_valid_i & instr_ready_o.
- flush_i  in  1  abort an in-progress collection (branch/exception).
- std_valid_o  out  1  non-custom word forwarded.
- std_instr_o  out  32  forwarded word (= instr_i).
- std_ready_i  in  1  standard decoder ready.
- exec_req_o  out  1  request to exec block.
- exec_gnt_i  in  1  exec grant.
- exec_dne_i  in  1  exec done, one-cycle pulse.
- instr_o  out  32  latched header.
- func3_o  out  3  header[14:12].
- funct2_o  out  2  header[26:25].
- imm32_o  out  IMM32_OPS*32  immediates; slot k = bits [32k+31:32k].
- imm32_valid_o  out  IMM32_OPS  per-slot valid.
- illegal_o  out  1  one-cycle pulse: unsupported immediate count.
- busy_o  out  1  state != IDLE.

Behaviour:
- Header detection: a word accepted in IDLE with instr_i[6:0]==CUSTOM_OPCODE is a header. Immediate count n_imm = instr_i[26:25]+1, range 1..4.
- FSM states: IDLE, COLLECT, REQ, WAIT_DNE.
- IDLE:
  - Non-custom word: std_valid_o=instr_valid_i; instr_ready_o=std_ready_i (combinational pass-through, no state change).
  - Custom word: instr_ready_o=1, std_valid_o=0.
  - Accepted header with n_imm<=IMM32_OPS: latch header into instr_o/func3_o/funct2_o, clear imm32_valid_o, load remaining counter with n_imm, go to COLLECT.
  - Accepted header with n_imm>IMM32_OPS: consume header only, pulse illegal_o the next cycle, stay IDLE, no other outputs change.
- COLLECT:
  - instr_ready_o=1, std_valid_o=0.
  - Each accepted word goes to slot (n_imm - remaining) and sets that slot's imm32_valid_o bit. remaining decrements.
  - Words are taken verbatim; a word equal to CUSTOM_OPCODE is not treated as a header.
  - When the last word is accepted, go to REQ. exec_req_o rises the cycle after the last immediate is accepted.
  - flush_i=1 (priority over an accept in the same cycle): word not accepted, imm32_valid_o cleared, go to IDLE, no request issued.
- REQ:
  - exec_req_o=1, instr_ready_o=0. flush_i ignored.
  - exec_gnt_i=1 moves to WAIT_DNE. exec_req_o drops the next cycle; same-cycle req/gnt is legal.
- WAIT_DNE:
  - exec_req_o=0, instr_ready_o=0. flush_i ignored.
  - exec_dne_i=1: clear imm32_valid_o, go to IDLE. A new header can be accepted the following cycle.
- exec_dne_i outside WAIT_DNE is ignored; this includes dne coincident with gnt.
- Stability: instr_o, func3_o, funct2_o, imm32_o and imm32_valid_o are stable from REQ entry until dne.
- Unused imm32_o slots read 0.
- Reset (synchronous, any state, including mid-collection or mid-request):
  - FSM to IDLE.
  - exec_req_o=0, illegal_o=0, busy_o=0.
  - imm32_valid_o=0, imm32_o=0, instr_o=0, func3_o=0, funct2_o=0.
  - remaining counter = 0.
  - std_valid_o follows the IDLE rules (0 when instr_valid_i=0).
- Gaps: instr_valid_i low during COLLECT simply stalls; there is no timeout.

Test Plan:
- Pass-through: instr_i=32'h00A00093 (addi), std_ready_i=0 then 1 -> std_valid_o=1, instr_ready_o mirrors std_ready_i, exec_req_o stays 0.
- Two-immediate collect:
  - Stimulus: header 32'h0200600B (funct2=1, func3=6), then 32'hDEADBEEF, 32'h12345678 back-to-back; gnt 2 cycles after req; dne 3 cycles after gnt.
  - Response: exec_req_o rises cycle 3, imm32_valid_o=4'b0011, slot0=DEADBEEF, slot1=12345678, func3_o=6, instr_ready_o=0 until the cycle after dne.
- Same-cycle gnt plus instr_valid_i gaps: 4-immediate header (funct2=3) with one idle cycle between immediates; gnt asserted with req -> req high exactly 1 cycle; all 4 valid bits set; completion on dne.
- Illegal: IMM32_OPS=2, header funct2=3 -> illegal_o pulses 1 cycle, busy_o stays 0, next word 32'h0000000B starts a fresh collect.
- Flush: flush_i after 1 of 3 immediates -> IDLE, imm32_valid_o=0, no exec_req_o. A flush asserted later in REQ has no effect.
- Reset in WAIT_DNE: rst_i high 1 cycle -> all outputs at reset values next cycle; a late exec_dne_i afterwards is ignored.

Source files
------------

// File: rtl/isolde_imm_collector.sv
// isolde_imm_collector
// Front end of the ISOLDE fetch-to-exec handshake. Ordinary fetch words go
// straight to the standard decoder. A custom-opcode header starts the
// collection of its 1..4 trailing immediate words. The header and its
// immediates are then held as one stable exec request until the exec block
// reports done.

module isolde_imm_collector #(
  parameter int         IMM32_OPS     = 4,
  parameter logic [6:0] CUSTOM_OPCODE = 7'h0B
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // fetch word stream
  input  logic                      instr_valid_i,
  input  logic [31:0]               instr_i,
  output logic                      instr_ready_o,
  input  logic                      flush_i,
  // standard decode path
  output logic                      std_valid_o,
  output logic [31:0]               std_instr_o,
  input  logic                      std_ready_i,
  // exec request
  output logic                      exec_req_o,
  input  logic                      exec_gnt_i,
  input  logic                      exec_dne_i,
  output logic [31:0]               instr_o,
  output logic [2:0]                func3_o,
  output logic [1:0]                funct2_o,
  output logic [IMM32_OPS*32-1:0]   imm32_o,
  output logic [IMM32_OPS-1:0]      imm32_valid_o,
  output logic                      illegal_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_REQ,
    ST_WAIT_DNE
  } state_t;

  // Slot count in the same 3-bit width as the immediate counters.
  localparam logic [2:0] LP_OPS = 3'(IMM32_OPS);

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0]          r_instr;
  logic [31:0]          r_imm [IMM32_OPS];
  logic [IMM32_OPS-1:0] r_imm_valid;
  logic [2:0]           r_remaining;
  logic [2:0]           r_n_imm;
  logic                 r_illegal;

  logic       w_is_custom;
  logic [2:0] w_n_imm;
  logic [2:0] w_slot;
  logic       w_hdr_load;
  logic       w_hdr_illegal;
  logic       w_imm_load;
  logic       w_clear;

  assign w_is_custom = (instr_i[6:0] == CUSTOM_OPCODE);
  // funct2 encodes the immediate count minus one.
  assign w_n_imm     = {1'b0, instr_i[26:25]} + 3'd1;
  // Immediates fill slots in arrival order: 0, 1, 2, ...
  assign w_slot      = r_n_imm - r_remaining;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic, handshake outputs and datapath strobes.
  always_comb begin
    w_state_next  = r_state;
    instr_ready_o = 1'b0;
    std_valid_o   = 1'b0;
    exec_req_o    = 1'b0;
    w_hdr_load    = 1'b0;
    w_hdr_illegal = 1'b0;
    w_imm_load    = 1'b0;
    w_clear       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_is_custom) begin
          // Headers are always consumed here, never offered to the decoder.
          instr_ready_o = 1'b1;
          if (instr_valid_i) begin
            if (w_n_imm <= LP_OPS) begin
              w_hdr_load   = 1'b1;
              w_state_next = ST_COLLECT;
            end else begin
              w_hdr_illegal = 1'b1;
            end
          end
        end else begin
          // Plain instructions: combinational pass-through.
          std_valid_o   = instr_valid_i;
          instr_ready_o = std_ready_i;
        end
      end
      ST_COLLECT: begin
        if (flush_i) begin
          // Flush wins over a word offered in the same cycle.
          w_clear      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          instr_ready_o = 1'b1;
          if (instr_valid_i) begin
            w_imm_load = 1'b1;
            if (r_remaining == 3'd1) begin
              w_state_next = ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        exec_req_o = 1'b1;
        if (exec_gnt_i) begin
          w_state_next = ST_WAIT_DNE;
        end
      end
      ST_WAIT_DNE: begin
        if (exec_dne_i) begin
          w_clear      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Header latch, immediate slots, remaining counter and illegal pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_instr     <= '0;
      r_imm_valid <= '0;
      r_remaining <= '0;
      r_n_imm     <= '0;
      r_illegal   <= 1'b0;
      for (int k = 0; k < IMM32_OPS; k++) begin
        r_imm[k] <= '0;
      end
    end else begin
      // An unsupported header is swallowed and flagged for exactly one cycle.
      r_illegal <= w_hdr_illegal;
      if (w_hdr_load) begin
        r_instr     <= instr_i;
        r_imm_valid <= '0;
        r_remaining <= w_n_imm;
        r_n_imm     <= w_n_imm;
      end else if (w_imm_load) begin
        for (int k = 0; k < IMM32_OPS; k++) begin
          if (w_slot == 3'(k)) begin
            r_imm[k]       <= instr_i;
            r_imm_valid[k] <= 1'b1;
          end
        end
        r_remaining <= r_remaining - 3'd1;
      end else if (w_clear) begin
        r_imm_valid <= '0;
        r_remaining <= '0;
      end
    end
  end

  // Slots without a valid immediate read as zero, so leftovers from an
  // earlier, longer request never leak into a shorter one.
  genvar gi;
  generate
    for (gi = 0; gi < IMM32_OPS; gi++) begin : g_slot
      assign imm32_o[gi*32 +: 32] = r_imm[gi] & {32{r_imm_valid[gi]}};
    end
  endgenerate

  assign std_instr_o   = instr_i;
  assign instr_o       = r_instr;
  assign func3_o       = r_instr[14:12];
  assign funct2_o      = r_instr[26:25];
  assign imm32_valid_o = r_imm_valid;
  assign illegal_o     = r_illegal;
  assign busy_o        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_isolde_imm_collector.sv
// Directed testbench for isolde_imm_collector. u_dut uses the default
// 4 slots; u_dut2 uses 2 slots to exercise the unsupported-count path.

module tb_isolde_imm_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i;
  logic         instr_valid_i, flush_i, std_ready_i, exec_gnt_i, exec_dne_i;
  logic [31:0]  instr_i;
  logic         instr_ready_o, std_valid_o, exec_req_o, illegal_o, busy_o;
  logic [31:0]  std_instr_o, instr_o;
  logic [2:0]   func3_o;
  logic [1:0]   funct2_o;
  logic [127:0] imm32_o;
  logic [3:0]   imm32_valid_o;

  logic         b_valid, b_flush, b_std_ready, b_gnt, b_dne;
  logic [31:0]  b_instr;
  logic         b_ready, b_std_valid, b_req, b_illegal, b_busy;
  logic [31:0]  b_std_instr, b_instr_o;
  logic [2:0]   b_func3;
  logic [1:0]   b_funct2;
  logic [63:0]  b_imm;
  logic [1:0]   b_imm_valid;

  int n_tests = 0;
  int n_fail  = 0;

  isolde_imm_collector #(.IMM32_OPS(4), .CUSTOM_OPCODE(7'h0B)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_i(instr_i), .instr_ready_o(instr_ready_o),
    .flush_i(flush_i),
    .std_valid_o(std_valid_o), .std_instr_o(std_instr_o), .std_ready_i(std_ready_i),
    .exec_req_o(exec_req_o), .exec_gnt_i(exec_gnt_i), .exec_dne_i(exec_dne_i),
    .instr_o(instr_o), .func3_o(func3_o), .funct2_o(funct2_o),
    .imm32_o(imm32_o), .imm32_valid_o(imm32_valid_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  isolde_imm_collector #(.IMM32_OPS(2), .CUSTOM_OPCODE(7'h0B)) u_dut2 (
    .clk_i(clk), .rst_i(rst_i),
    .instr_valid_i(b_valid), .instr_i(b_instr), .instr_ready_o(b_ready),
    .flush_i(b_flush),
    .std_valid_o(b_std_valid), .std_instr_o(b_std_instr), .std_ready_i(b_std_ready),
    .exec_req_o(b_req), .exec_gnt_i(b_gnt), .exec_dne_i(b_dne),
    .instr_o(b_instr_o), .func3_o(b_func3), .funct2_o(b_funct2),
    .imm32_o(b_imm), .imm32_valid_o(b_imm_valid),
    .illegal_o(b_illegal), .busy_o(b_busy)
  );

  task automatic test_reset();
    rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    n_tests++;
    if ({exec_req_o, illegal_o, busy_o, std_valid_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {exec_req_o, illegal_o, busy_o, std_valid_o});
    end
    n_tests++;
    if ({instr_o, func3_o, funct2_o, imm32_valid_o} !== 41'd0 || imm32_o !== 128'd0) begin
      n_fail++; $display("FAIL reset_data instr=%h valid=%b imm=%h exp=0", instr_o, imm32_valid_o, imm32_o);
    end
    n_tests++;
    if ({b_busy, b_req, b_illegal} !== 3'b000) begin
      n_fail++; $display("FAIL reset_dut2 got=%b exp=000", {b_busy, b_req, b_illegal});
    end
    rst_i = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    instr_i = 32'h00A00093; instr_valid_i = 1'b1; std_ready_i = 1'b0; #1;
    n_tests++;
    if ({std_valid_o, instr_ready_o, exec_req_o} !== 3'b100 || std_instr_o !== 32'h00A00093) begin
      n_fail++; $display("FAIL pass_stall sv/rdy/req=%b instr=%h exp=100 00a00093",
                         {std_valid_o, instr_ready_o, exec_req_o}, std_instr_o);
    end
    @(negedge clk);
    std_ready_i = 1'b1; #1;
    n_tests++;
    if ({std_valid_o, instr_ready_o, busy_o} !== 3'b110) begin
      n_fail++; $display("FAIL pass_go sv/rdy/busy=%b exp=110", {std_valid_o, instr_ready_o, busy_o});
    end
    @(negedge clk);
    instr_valid_i = 1'b0; std_ready_i = 1'b0; instr_i = '0; #1;
    n_tests++;
    if ({busy_o, exec_req_o} !== 2'b00) begin
      n_fail++; $display("FAIL pass_after busy/req=%b exp=00", {busy_o, exec_req_o});
    end
    $display("[TB] test_pass_through done");
  endtask

  task automatic test_two_imm();
    @(negedge clk);
    instr_i = 32'h0200600B; instr_valid_i = 1'b1; #1;
    n_tests++;
    if ({instr_ready_o, std_valid_o} !== 2'b10) begin
      n_fail++; $display("FAIL two_hdr rdy/sv=%b exp=10", {instr_ready_o, std_valid_o});
    end
    @(negedge clk);
    instr_i = 32'hDEADBEEF; #1;
    n_tests++;
    if ({busy_o, exec_req_o} !== 2'b10 || funct2_o !== 2'd1) begin
      n_fail++; $display("FAIL two_collect busy/req=%b funct2=%0d exp=10 1", {busy_o, exec_req_o}, funct2_o);
    end
    @(negedge clk);
    instr_i = 32'h12345678; #1;
    n_tests++;
    if (exec_req_o !== 1'b0 || imm32_valid_o !== 4'b0001) begin
      n_fail++; $display("FAIL two_mid req=%b valid=%b exp=0 0001", exec_req_o, imm32_valid_o);
    end
    @(negedge clk);
    instr_valid_i = 1'b0; instr_i = '0; #1;
    n_tests++;
    if (exec_req_o !== 1'b1 || instr_ready_o !== 1'b0 || imm32_valid_o !== 4'b0011) begin
      n_fail++; $display("FAIL two_req req=%b rdy=%b valid=%b exp=1 0 0011", exec_req_o, instr_ready_o, imm32_valid_o);
    end
    n_tests++;
    if (imm32_o !== {64'd0, 32'h12345678, 32'hDEADBEEF} || func3_o !== 3'd6 || instr_o !== 32'h0200600B) begin
      n_fail++; $display("FAIL two_data imm=%h func3=%0d instr=%h exp=...12345678deadbeef 6 0200600b",
                         imm32_o, func3_o, instr_o);
    end
    @(negedge clk); #1;
    n_tests++;
    if (exec_req_o !== 1'b1) begin
      n_fail++; $display("FAIL two_req_hold req=%b exp=1", exec_req_o);
    end
    @(negedge clk);
    exec_gnt_i = 1'b1; #1;
    n_tests++;
    if (exec_req_o !== 1'b1) begin
      n_fail++; $display("FAIL two_req_gnt req=%b exp=1", exec_req_o);
    end
    @(negedge clk);
    exec_gnt_i = 1'b0; #1;
    n_tests++;
    if ({exec_req_o, busy_o, instr_ready_o} !== 3'b010) begin
      n_fail++; $display("FAIL two_wait req/busy/rdy=%b exp=010", {exec_req_o, busy_o, instr_ready_o});
    end
    @(negedge clk); #1;
    @(negedge clk);
    exec_dne_i = 1'b1; #1;
    n_tests++;
    if (instr_ready_o !== 1'b0 || imm32_valid_o !== 4'b0011 || imm32_o[63:0] !== {32'h12345678, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL two_dne_cycle rdy=%b valid=%b imm=%h exp=0 0011 12345678deadbeef",
                         instr_ready_o, imm32_valid_o, imm32_o[63:0]);
    end
    @(negedge clk);
    exec_dne_i = 1'b0; instr_i = 32'h0000000B; #1;
    n_tests++;
    if ({instr_ready_o, busy_o} !== 2'b10 || imm32_valid_o !== 4'b0000) begin
      n_fail++; $display("FAIL two_done rdy/busy=%b valid=%b exp=10 0000", {instr_ready_o, busy_o}, imm32_valid_o);
    end
    instr_i = '0;
    $display("[TB] test_two_imm done");
  endtask

  task automatic test_gaps_same_gnt();
    logic [31:0] words [4];
    words[0] = 32'h11111111; words[1] = 32'h0000000B;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    @(negedge clk);
    instr_i = 32'h0600000B; instr_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instr_valid_i = 1'b0; instr_i = 32'hFFFFFFFF; #1;
      n_tests++;
      if ({instr_ready_o, busy_o, exec_req_o} !== 3'b110) begin
        n_fail++; $display("FAIL gap_stall%0d rdy/busy/req=%b exp=110", i, {instr_ready_o, busy_o, exec_req_o});
      end
      @(negedge clk);
      instr_valid_i = 1'b1; instr_i = words[i];
    end
    @(negedge clk);
    instr_valid_i = 1'b0; instr_i = '0; exec_gnt_i = 1'b1; exec_dne_i = 1'b1; #1;
    n_tests++;
    if (exec_req_o !== 1'b1 || imm32_valid_o !== 4'b1111 || funct2_o !== 2'd3) begin
      n_fail++; $display("FAIL gap_req req=%b valid=%b funct2=%0d exp=1 1111 3", exec_req_o, imm32_valid_o, funct2_o);
    end
    n_tests++;
    if (imm32_o !== {32'h44444444, 32'h33333333, 32'h0000000B, 32'h11111111}) begin
      n_fail++; $display("FAIL gap_data imm=%h exp=44444444333333330000000b11111111", imm32_o);
    end
    @(negedge clk);
    exec_gnt_i = 1'b0; exec_dne_i = 1'b0; #1;
    n_tests++;
    if ({exec_req_o, busy_o} !== 2'b01) begin
      n_fail++; $display("FAIL gap_req_once req/busy=%b exp=01", {exec_req_o, busy_o});
    end
    @(negedge clk);
    exec_dne_i = 1'b1;
    @(negedge clk);
    exec_dne_i = 1'b0; #1;
    n_tests++;
    if (busy_o !== 1'b0 || imm32_valid_o !== 4'b0000) begin
      n_fail++; $display("FAIL gap_done busy=%b valid=%b exp=0 0000", busy_o, imm32_valid_o);
    end
    $display("[TB] test_gaps_same_gnt done");
  endtask

  task automatic test_illegal();
    @(negedge clk);
    b_instr = 32'h0600000B; b_valid = 1'b1; #1;
    n_tests++;
    if (b_ready !== 1'b1) begin
      n_fail++; $display("FAIL ill_hdr_rdy got=%b exp=1", b_ready);
    end
    @(negedge clk);
    b_valid = 1'b0; b_instr = '0; #1;
    n_tests++;
    if ({b_illegal, b_busy, b_req} !== 3'b100 || b_instr_o !== 32'd0 || b_imm_valid !== 2'b00) begin
      n_fail++; $display("FAIL ill_pulse ill/busy/req=%b instr=%h valid=%b exp=100 0 00",
                         {b_illegal, b_busy, b_req}, b_instr_o, b_imm_valid);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({b_illegal, b_busy} !== 2'b00) begin
      n_fail++; $display("FAIL ill_once ill/busy=%b exp=00", {b_illegal, b_busy});
    end
    @(negedge clk);
    b_instr = 32'h0000000B; b_valid = 1'b1;
    @(negedge clk);
    b_instr = 32'h11111111; #1;
    n_tests++;
    if (b_busy !== 1'b1) begin
      n_fail++; $display("FAIL ill_fresh busy=%b exp=1", b_busy);
    end
    @(negedge clk);
    b_valid = 1'b0; b_instr = '0; #1;
    n_tests++;
    if (b_req !== 1'b1 || b_imm_valid !== 2'b01 || b_imm !== {32'h0, 32'h11111111} || b_instr_o !== 32'h0000000B) begin
      n_fail++; $display("FAIL ill_fresh_req req=%b valid=%b imm=%h instr=%h exp=1 01 0000000011111111 0000000b",
                         b_req, b_imm_valid, b_imm, b_instr_o);
    end
    @(negedge clk);
    b_gnt = 1'b1;
    @(negedge clk);
    b_gnt = 1'b0; b_dne = 1'b1;
    @(negedge clk);
    b_dne = 1'b0; #1;
    n_tests++;
    if (b_busy !== 1'b0) begin
      n_fail++; $display("FAIL ill_done busy=%b exp=0", b_busy);
    end
    $display("[TB] test_illegal done");
  endtask

  task automatic test_flush();
    @(negedge clk);
    instr_i = 32'h0400000B; instr_valid_i = 1'b1;
    @(negedge clk);
    instr_i = 32'hAAAA0001;
    @(negedge clk);
    instr_i = 32'hAAAA0002; flush_i = 1'b1; #1;
    n_tests++;
    if (instr_ready_o !== 1'b0 || imm32_valid_o !== 4'b0001) begin
      n_fail++; $display("FAIL flush_cycle rdy=%b valid=%b exp=0 0001", instr_ready_o, imm32_valid_o);
    end
    @(negedge clk);
    flush_i = 1'b0; instr_valid_i = 1'b0; instr_i = '0; #1;
    n_tests++;
    if ({busy_o, exec_req_o} !== 2'b00 || imm32_valid_o !== 4'b0000 || imm32_o !== 128'd0) begin
      n_fail++; $display("FAIL flush_idle busy/req=%b valid=%b imm=%h exp=00 0000 0",
                         {busy_o, exec_req_o}, imm32_valid_o, imm32_o);
    end
    @(negedge clk); #1;
    n_tests++;
    if (exec_req_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_noreq req=%b exp=0", exec_req_o);
    end
    @(negedge clk);
    instr_i = 32'h0000100B; instr_valid_i = 1'b1;
    @(negedge clk);
    instr_i = 32'h55AA55AA;
    @(negedge clk);
    instr_valid_i = 1'b0; instr_i = '0; flush_i = 1'b1; #1;
    n_tests++;
    if (exec_req_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_req_enter req=%b exp=1", exec_req_o);
    end
    @(negedge clk);
    flush_i = 1'b0; #1;
    n_tests++;
    if ({exec_req_o, busy_o} !== 2'b11 || imm32_valid_o !== 4'b0001 || imm32_o[31:0] !== 32'h55AA55AA || func3_o !== 3'd1) begin
      n_fail++; $display("FAIL flush_in_req req/busy=%b valid=%b slot0=%h func3=%0d exp=11 0001 55aa55aa 1",
                         {exec_req_o, busy_o}, imm32_valid_o, imm32_o[31:0], func3_o);
    end
    @(negedge clk);
    exec_gnt_i = 1'b1;
    @(negedge clk);
    exec_gnt_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; exec_dne_i = 1'b1; #1;
    n_tests++;
    if ({busy_o, exec_req_o} !== 2'b10) begin
      n_fail++; $display("FAIL flush_in_wait busy/req=%b exp=10", {busy_o, exec_req_o});
    end
    @(negedge clk);
    exec_dne_i = 1'b0; #1;
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_done busy=%b exp=0", busy_o);
    end
    $display("[TB] test_flush done");
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    instr_i = 32'h0000700B; instr_valid_i = 1'b1;
    @(negedge clk);
    instr_i = 32'hCAFEF00D;
    @(negedge clk);
    instr_valid_i = 1'b0; instr_i = '0; exec_gnt_i = 1'b1;
    @(negedge clk);
    exec_gnt_i = 1'b0; #1;
    n_tests++;
    if ({busy_o, exec_req_o} !== 2'b10 || func3_o !== 3'd7) begin
      n_fail++; $display("FAIL rw_wait busy/req=%b func3=%0d exp=10 7", {busy_o, exec_req_o}, func3_o);
    end
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; #1;
    n_tests++;
    if ({exec_req_o, illegal_o, busy_o, std_valid_o, instr_ready_o} !== 5'b00000) begin
      n_fail++; $display("FAIL rw_ctrl req/ill/busy/sv/rdy=%b exp=00000",
                         {exec_req_o, illegal_o, busy_o, std_valid_o, instr_ready_o});
    end
    n_tests++;
    if ({instr_o, func3_o, funct2_o, imm32_valid_o} !== 41'd0 || imm32_o !== 128'd0) begin
      n_fail++; $display("FAIL rw_data instr=%h func3=%0d valid=%b imm=%h exp=0",
                         instr_o, func3_o, imm32_valid_o, imm32_o);
    end
    @(negedge clk);
    exec_dne_i = 1'b1;
    @(negedge clk);
    exec_dne_i = 1'b0; instr_i = 32'h00A00093; instr_valid_i = 1'b1; std_ready_i = 1'b1; #1;
    n_tests++;
    if ({busy_o, exec_req_o, illegal_o, std_valid_o, instr_ready_o} !== 5'b00011) begin
      n_fail++; $display("FAIL rw_late_dne busy/req/ill/sv/rdy=%b exp=00011",
                         {busy_o, exec_req_o, illegal_o, std_valid_o, instr_ready_o});
    end
    @(negedge clk);
    instr_valid_i = 1'b0; std_ready_i = 1'b0; instr_i = '0;
    $display("[TB] test_reset_in_wait done");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    instr_i = 32'h0000000B; instr_valid_i = 1'b1;
    @(negedge clk);
    instr_i = 32'h01010101;
    @(negedge clk);
    instr_valid_i = 1'b0; instr_i = '0; exec_gnt_i = 1'b1;
    @(negedge clk);
    exec_gnt_i = 1'b0; exec_dne_i = 1'b1;
    @(negedge clk);
    exec_dne_i = 1'b0; instr_i = 32'h0200200B; instr_valid_i = 1'b1; #1;
    n_tests++;
    if ({instr_ready_o, busy_o} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_hdr rdy/busy=%b exp=10", {instr_ready_o, busy_o});
    end
    @(negedge clk);
    instr_i = 32'hA0A0A0A0; #1;
    n_tests++;
    if (busy_o !== 1'b1 || func3_o !== 3'd2 || funct2_o !== 2'd1 || imm32_valid_o !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_latch busy=%b func3=%0d funct2=%0d valid=%b exp=1 2 1 0000",
                         busy_o, func3_o, funct2_o, imm32_valid_o);
    end
    @(negedge clk);
    instr_i = 32'hB0B0B0B0;
    @(negedge clk);
    instr_valid_i = 1'b0; instr_i = '0; #1;
    n_tests++;
    if (exec_req_o !== 1'b1 || imm32_valid_o !== 4'b0011 || imm32_o !== {64'd0, 32'hB0B0B0B0, 32'hA0A0A0A0}) begin
      n_fail++; $display("FAIL b2b_req req=%b valid=%b imm=%h exp=1 0011 ...b0b0b0b0a0a0a0a0",
                         exec_req_o, imm32_valid_o, imm32_o);
    end
    @(negedge clk);
    exec_gnt_i = 1'b1;
    @(negedge clk);
    exec_gnt_i = 1'b0; exec_dne_i = 1'b1;
    @(negedge clk);
    exec_dne_i = 1'b0; #1;
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done busy=%b exp=0", busy_o);
    end
    $display("[TB] test_back_to_back done");
  endtask

  initial begin
    rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0; flush_i = 1'b0;
    std_ready_i = 1'b0; exec_gnt_i = 1'b0; exec_dne_i = 1'b0;
    b_valid = 1'b0; b_instr = '0; b_flush = 1'b0; b_std_ready = 1'b0;
    b_gnt = 1'b0; b_dne = 1'b0;
    test_reset();
    test_pass_through();
    test_two_imm();
    test_gaps_same_gnt();
    test_illegal();
    test_flush();
    test_reset_in_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
